pe_unit: RTL and testbench

Processing element for an output-stationary systolic matrix-multiply array. Every clock it multiplies the operand arriving from above by the operand arriving from the left and adds the product into a local accumulator. It forwards both operands, registered, to its lower and right neighbours. Tiling N×N instances, with each `down_o`/`right_o` feeding the next PE's `up_i`/`left_i`, yields one result element per PE on `res_o`.

---
 rtl/pe_pkg.sv | 11 +
 rtl/pe_mac.sv | 38 +++
 rtl/pe_unit.sv | 47 ++++
 tb/tb_pe_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the systolic processing element and array-level code.
package pe_pkg;

   // Default operand width; the accumulator is twice as wide so products never truncate.
   localparam int DATA_WIDTH = 32;
   localparam int RES_WIDTH  = 2 * DATA_WIDTH;

   // Accumulator / result type at the default width.
   typedef logic [RES_WIDTH-1:0] res_t;

endpackage : pe_pkg

// File: rtl/pe_mac.sv
// Unsigned full-width multiply-accumulate with asynchronous active-low reset.
// The accumulator wraps modulo 2^(2*DATA_WIDTH); reset is the only way to clear it.
module pe_mac #(
   parameter int DATA_WIDTH = pe_pkg::DATA_WIDTH
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [DATA_WIDTH-1:0]     a_i,
   input  logic [DATA_WIDTH-1:0]     b_i,
   output logic [2*DATA_WIDTH-1:0]   acc_o
);

   import pe_pkg::*;

   localparam int RES_W = 2 * DATA_WIDTH;

   logic [RES_W-1:0] w_prod;
   logic [RES_W-1:0] w_sum;
   logic [RES_W-1:0] r_acc;

   // Both operands are widened before multiplying so the product keeps every bit.
   assign w_prod = RES_W'(a_i) * RES_W'(b_i);

   // Carry out of the top bit is dropped on purpose: the sum wraps.
   assign w_sum  = r_acc + w_prod;

   // Accumulator register; reset discards any partial sum immediately.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_acc <= '0;
      end else begin
         r_acc <= w_sum;
      end
   end

   assign acc_o = r_acc;

endmodule : pe_mac

// File: rtl/pe_unit.sv
// Output-stationary systolic PE: accumulates up_i*left_i locally and forwards
// both operands, registered, to the neighbours below and to the right.
module pe_unit #(
   parameter int DATA_WIDTH = pe_pkg::DATA_WIDTH
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [DATA_WIDTH-1:0]     up_i,
   input  logic [DATA_WIDTH-1:0]     left_i,
   output logic [DATA_WIDTH-1:0]     down_o,
   output logic [DATA_WIDTH-1:0]     right_o,
   output logic [2*DATA_WIDTH-1:0]   res_o
);

   import pe_pkg::*;

   logic [DATA_WIDTH-1:0]   r_down;
   logic [DATA_WIDTH-1:0]   r_right;
   logic [2*DATA_WIDTH-1:0] w_acc;

   pe_mac #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mac (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .a_i    (up_i),
      .b_i    (left_i),
      .acc_o  (w_acc)
   );

   // Forwarding registers: one-cycle hop of each operand to the next PE, unmodified.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_down  <= '0;
         r_right <= '0;
      end else begin
         r_down  <= up_i;
         r_right <= left_i;
      end
   end

   assign down_o  = r_down;
   assign right_o = r_right;
   // Result comes straight from the accumulator register, no logic after it.
   assign res_o   = w_acc;

endmodule : pe_unit

// File: tb/tb_pe_unit.sv
// Scoreboard bench for pe_unit: stimulus pushes expected outputs, a monitor pops and compares.
module tb_pe_unit;
   import pe_pkg::*;

   localparam int W = 32;

   logic          clk;
   logic          rst_n;
   logic [W-1:0]  up;
   logic [W-1:0]  left;
   logic [W-1:0]  down;
   logic [W-1:0]  right;
   logic [2*W-1:0] res;

   int total = 0;
   int bad   = 0;

   typedef struct {
      res_t         res;
      logic [W-1:0] dn;
      logic [W-1:0] rt;
      string        tag;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } pair_t;

   exp_t  sb_q[$];
   pair_t hist[$];   // operand pairs applied since the last reset

   pe_unit #(.DATA_WIDTH(W)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .up_i    (up),
      .left_i  (left),
      .down_o  (down),
      .right_o (right),
      .res_o   (res)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference: result is the wrapped sum of all products since reset.
   function automatic res_t model_sum();
      res_t s = '0;
      foreach (hist[i]) s = s + res_t'(hist[i].a) * res_t'(hist[i].b);
      return s;
   endfunction

   // Called at a negedge with reset released: apply operands for the next edge.
   task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
      exp_t e;
      up   = a;
      left = b;
      hist.push_back('{a: a, b: b});
      e.res = model_sum();
      e.dn  = a;
      e.rt  = b;
      e.tag = tag;
      sb_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Asynchronous reset pulse between edges, checking outputs clear before any edge.
   task automatic async_reset(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      chk({tag, "_res0"},   res, '0);
      chk({tag, "_down0"},  {32'd0, down}, '0);
      chk({tag, "_right0"}, {32'd0, right}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      hist.delete();
   endtask

   // Monitor: compare DUT outputs 1 time unit after each active edge.
   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk({e.tag, "_res"},   res, e.res);
         chk({e.tag, "_down"},  {32'd0, down},  {32'd0, e.dn});
         chk({e.tag, "_right"}, {32'd0, right}, {32'd0, e.rt});
      end
   end

   initial begin
      logic [W-1:0] ra, rb;
      rst_n = 1'b0;
      up    = 32'd5;
      left  = 32'd3;

      // Reset held: outputs zero through t=10
      #1;
      chk("rst_res_t1", res, '0);
      chk("rst_down_t1", {32'd0, down}, '0);
      #8;
      chk("rst_res_t9", res, '0);
      chk("rst_right_t9", {32'd0, right}, '0);
      @(negedge clk);   // t=10
      rst_n = 1'b1;
      hist.delete();
      step(32'd5, 32'd3, "acc1");
      step(32'd5, 32'd3, "acc2");
      step(32'd5, 32'd3, "acc3");
      chk("acc_const45", res, 64'd45);

      // Changing operands
      async_reset("r1");
      step(32'd2, 32'd4, "chg1");
      step(32'd7, 32'd1, "chg2");
      step(32'd0, 32'd9, "chg3");
      chk("chg_const15", res, 64'd15);

      // Full-width product and wrap-around
      async_reset("r2");
      step(32'hFFFF_FFFF, 32'hFFFF_FFFF, "full1");
      chk("full_const", res, 64'hFFFF_FFFE_0000_0001);
      step(32'hFFFF_FFFF, 32'hFFFF_FFFF, "wrap2");
      chk("wrap2_const", res, 64'hFFFF_FFFC_0000_0002);
      step(32'hFFFF_FFFF, 32'hFFFF_FFFF, "wrap3");
      chk("wrap3_const", res, 64'hFFFF_FFFA_0000_0003);

      // Asynchronous reset mid-accumulation, then restart from zero
      async_reset("r3");
      step(32'd1, 32'd1, "restart");
      chk("restart_const", res, 64'd1);

      // Idle: zero operand on top keeps the sum at zero
      async_reset("r4");
      for (int i = 0; i < 5; i++) step(32'd0, 32'd123, "idle");
      chk("idle_res", res, '0);
      chk("idle_right", {32'd0, right}, 64'd123);

      // Randomized operands with occasional mid-stream resets
      async_reset("r5");
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0:       begin ra = $urandom; rb = $urandom; end
            1:       begin ra = $urandom_range(0, 255); rb = $urandom_range(0, 255); end
            2:       begin ra = 32'hFFFF_FFFF - $urandom_range(0, 15); rb = $urandom; end
            default: begin ra = $urandom_range(0, 3); rb = 32'hFFFF_FFFF; end
         endcase
         step(ra, rb, "rnd");
         if ($urandom_range(0, 19) == 0) async_reset("rr");
      end

      // Drain: every expected response must have been consumed
      @(negedge clk);
      chk("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard bound on run time.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, total=%0d", total);
      $fatal(1, "timeout");
   end

endmodule : tb_pe_unit
